mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the out-of-order core's clients and the 8-bit unified RAM/IO port.
- Arbitrates between the instruction-fetch client and the load/store buffer (LSB) client.
- Splits 1/2/4-byte requests into sequential byte accesses, reassembles little-endian read data, and returns a one-cycle completion pulse per request.
- Handles IO-write back-pressure and pipeline rollback.

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.
- IO_TAG, 2'b11, value of addr[17:16] that marks an IO-mapped address.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- rollback  in  1  pipeline flush pulse
- ram_din  in  8  byte read from RAM; valid one cycle after its address is presented
- ram_dout  out  8  byte to write
- ram_a  out  ADDR_WIDTH  byte address to RAM
- ram_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO write FIFO full
- if_enable  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_WIDTH  fetch address; always 4 bytes
- if_valid  out  1  fetch done pulse
- if_data  out  32  fetched word
- lsb_enable  in  1  LSB request, held until lsb_valid
- lsb_wr  in  1  0 = read, 1 = write
- lsb_addr  in  ADDR_WIDTH  start address
- lsb_data  in  32  store data; low lsb_len bytes are used
- lsb_len  in  3  1, 2 or 4
- lsb_valid  out  1  LSB done pulse
- lsb_dout  out  32  load data, zero-extended (the LSB performs sign extension)

Behaviour:
- Reset: state IDLE; ram_a=0, ram_dout=0, ram_wr=0, if_valid=0, lsb_valid=0, if_data=0, lsb_dout=0; counters cleared. Reset mid-transfer drops it with no valid pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE: accepts at a clock edge where rollback=0.
  - LSB request has priority over fetch.
  - The selected request is latched: client, wr, addr, len (4 for fetch), data.
  - A read goes to READ; a write goes to WRITE.
- READ:
  - Cycle k (k = 0..len-1 after accept) drives ram_a = addr+k, ram_wr=0.
  - The byte arriving on ram_din in the following cycle is stored at bits [8k+7:8k].
  - Bytes at or beyond len are 0.
  - After the last byte is captured, the state moves to DONE and the client's valid and data are registered.
  - Latency: valid is high in cycle len+2 after the accept edge (word = 6, byte = 3).
- WRITE:
  - Cycle k drives ram_a = addr+k, ram_dout = data[8k+7:8k], ram_wr=1.
  - After byte len-1 the state moves to DONE with lsb_valid high in cycle len+1.
  - IO back-pressure: if addr[17:16]==IO_TAG and io_buffer_full=1 at the issuing edge, drive ram_wr=0 and re-issue the same byte next cycle. There is no cap on the number of retries.
- DONE:
  - valid is high for exactly one cycle.
  - Request inputs are ignored this cycle, because the client drops enable on this edge.
  - Next state is IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
- Rollback:
  - In READ (either client), the transfer is aborted at the rollback edge. Next state IDLE, no valid pulse, ram_wr=0.
  - In WRITE, rollback is ignored and the write always completes; committed stores survive flushes.
  - In IDLE, rollback blocks acceptance that cycle.
  - A valid already registered in DONE is not suppressed.
- rdy=0:
  - No state, counter or output register changes.
  - ram_wr output is forced 0 combinationally; the same byte is presented again when rdy returns.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Unaligned addresses are legal (byte-serial).
- lsb_len other than 1/2/4 is treated as 4.
- if_data and lsb_dout hold their last value outside valid cycles.

Decomposition:
- Shared defines file: True/False, state encodings (2 bits), IO_TAG, length encodings.
- No sub-module. Arbitration and the byte engine share a single counter and are kept inline in one FSM (around 200 lines).

Test Plan:
- LW, RAM[0x100..0x103]=78 56 34 12; lsb_enable, lsb_addr=0x100, lsb_len=4 -> ram_a 0x100..0x103 on consecutive cycles, lsb_valid=1 in cycle 6 with lsb_dout=0x12345678, one cycle only.
- Simultaneous if_enable (0x0) and lsb_enable (SB to 0x200, data 0xAB) -> write goes first: ram_wr=1, ram_a=0x200, ram_dout=0xAB, lsb_valid next cycle. Fetch accepted after DONE+IDLE, if_valid carries RAM[0..3].
- SW to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr=0 for 3 cycles, then bytes written at 0x30000..0x30003 and lsb_valid once.
- LH from 0x104 with rollback in cycle 2 -> no further ram_a advance, no lsb_valid, state IDLE; a new fetch issued the following cycle completes normally.
- SH to 0x208 with rollback in cycle 1 -> both bytes written, lsb_valid asserted.
- rdy low for 2 cycles mid LW -> ram_wr=0 and no progress while low; lsb_dout correct; valid delayed by exactly 2 cycles.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared encodings for the byte-serial memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam logic c_TRUE  = 1'b1;
    localparam logic c_FALSE = 1'b0;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [1:0] c_IO_TAG = 2'b11;

    localparam logic [2:0] c_LEN_BYTE = 3'd1;
    localparam logic [2:0] c_LEN_HALF = 3'd2;
    localparam logic [2:0] c_LEN_WORD = 3'd4;

    localparam logic c_CLIENT_IF  = 1'b0;
    localparam logic c_CLIENT_LSB = 1'b1;

    // Any length encoding other than byte/half is serviced as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            c_LEN_BYTE, c_LEN_HALF: return len;
            default:                return c_LEN_WORD;
        endcase
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Arbitrates fetch/LSB clients onto an 8-bit RAM/IO port,
//               serialising 1/2/4-byte requests into byte accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_TAG     = c_IO_TAG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_enable,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [31:0]           if_data,
    input  logic                  lsb_enable,
    input  logic                  lsb_wr,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_data,
    input  logic [2:0]            lsb_len,
    output logic                  lsb_valid,
    output logic [31:0]           lsb_dout
);

    logic [1:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [2:0]            len_q, len_d;
    logic                  client_q, client_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           buf_q, buf_d;
    logic [1:0]            rd_idx_q, rd_idx_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic                  ram_wr_q, ram_wr_d;
    logic                  if_valid_q, if_valid_d;
    logic                  lsb_valid_q, lsb_valid_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           lsb_dout_q, lsb_dout_d;

    logic                  w_accept;
    logic                  w_sel_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [1:0]            w_cnt_inc;
    logic [1:0]            w_last_idx;
    logic                  w_cap;
    logic                  w_rd_done;
    logic                  w_wr_done;
    logic                  w_io_sel;
    logic                  w_io_cur;
    logic                  w_io_inc;
    logic [31:0]           w_rd_word;

    assign w_accept   = (state_q == c_ST_IDLE) && !rollback && (lsb_enable || if_enable);
    assign w_sel_wr   = lsb_enable && lsb_wr;
    assign w_sel_addr = lsb_enable ? lsb_addr : if_addr;
    assign w_addr_inc = ram_a_q + ADDR_WIDTH'(1);
    assign w_cnt_inc  = cnt_q + 2'd1;
    assign w_last_idx = 2'(len_q - 3'd1);
    assign w_io_sel   = (w_sel_addr[17:16] == IO_TAG) && io_buffer_full;
    assign w_io_cur   = (ram_a_q[17:16] == IO_TAG) && io_buffer_full;
    assign w_io_inc   = (w_addr_inc[17:16] == IO_TAG) && io_buffer_full;

    // The RAM answers one cycle after it sees an address whether or not rdy is
    // high, so the read return path tracks the presented offset every clock.
    assign w_cap      = rd_vld_q && (state_q == c_ST_READ);
    assign w_rd_done  = w_cap && (rd_idx_q == w_last_idx);
    assign w_wr_done  = ram_wr_q && (cnt_q == w_last_idx);

    always_comb begin
        w_rd_word = buf_q;
        if (w_cap) begin
            w_rd_word[{rd_idx_q, 3'b000} +: 8] = ram_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            cnt_q       <= '0;
            len_q       <= c_LEN_WORD;
            client_q    <= c_CLIENT_IF;
            data_q      <= '0;
            buf_q       <= '0;
            rd_idx_q    <= '0;
            rd_vld_q    <= c_FALSE;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= c_FALSE;
            if_valid_q  <= c_FALSE;
            lsb_valid_q <= c_FALSE;
            if_data_q   <= '0;
            lsb_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            client_q    <= client_d;
            data_q      <= data_d;
            buf_q       <= buf_d;
            rd_idx_q    <= rd_idx_d;
            rd_vld_q    <= rd_vld_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_valid_q  <= if_valid_d;
            lsb_valid_q <= lsb_valid_d;
            if_data_q   <= if_data_d;
            lsb_dout_q  <= lsb_dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                c_ST_IDLE:  if (w_accept) state_d = w_sel_wr ? c_ST_WRITE : c_ST_READ;
                c_ST_READ:  if (rollback) state_d = c_ST_IDLE;
                            else if (w_rd_done) state_d = c_ST_DONE;
                c_ST_WRITE: if (w_wr_done) state_d = c_ST_DONE;
                c_ST_DONE:  state_d = c_ST_IDLE;
                default:    state_d = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        len_d       = len_q;
        client_d    = client_q;
        data_d      = data_q;
        buf_d       = w_cap ? w_rd_word : buf_q;
        rd_idx_d    = cnt_q;
        rd_vld_d    = (state_q == c_ST_READ);
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_valid_d  = if_valid_q;
        lsb_valid_d = lsb_valid_q;
        if_data_d   = if_data_q;
        lsb_dout_d  = lsb_dout_q;
        if (rdy) begin
            case (state_q)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        client_d   = lsb_enable ? c_CLIENT_LSB : c_CLIENT_IF;
                        len_d      = lsb_enable ? norm_len(lsb_len) : c_LEN_WORD;
                        data_d     = lsb_data;
                        cnt_d      = '0;
                        buf_d      = '0;
                        ram_a_d    = w_sel_addr;
                        ram_dout_d = lsb_data[7:0];
                        ram_wr_d   = w_sel_wr && !w_io_sel;
                    end
                end
                c_ST_READ: begin
                    if (!rollback) begin
                        if (w_rd_done) begin
                            if (client_q == c_CLIENT_LSB) begin
                                lsb_valid_d = c_TRUE;
                                lsb_dout_d  = w_rd_word;
                            end else begin
                                if_valid_d = c_TRUE;
                                if_data_d  = w_rd_word;
                            end
                        end else if (cnt_q != w_last_idx) begin
                            cnt_d   = w_cnt_inc;
                            ram_a_d = w_addr_inc;
                        end
                    end
                end
                c_ST_WRITE: begin
                    // ram_wr_q low means the last byte was held back by the IO FIFO.
                    if (!ram_wr_q) begin
                        ram_wr_d = !w_io_cur;
                    end else if (w_wr_done) begin
                        ram_wr_d    = c_FALSE;
                        lsb_valid_d = c_TRUE;
                    end else begin
                        cnt_d      = w_cnt_inc;
                        ram_a_d    = w_addr_inc;
                        ram_dout_d = data_q[{w_cnt_inc, 3'b000} +: 8];
                        ram_wr_d   = !w_io_inc;
                    end
                end
                c_ST_DONE: begin
                    if_valid_d  = c_FALSE;
                    lsb_valid_d = c_FALSE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_a     = ram_a_q;
        ram_dout  = ram_dout_q;
        ram_wr    = ram_wr_q && rdy;
        if_valid  = if_valid_q;
        if_data   = if_data_q;
        lsb_valid = lsb_valid_q;
        lsb_dout  = lsb_dout_q;
    end

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl with a byte-addressed memory
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, io_buffer_full;
    logic [7:0]  ram_din, ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        if_enable, if_valid;
    logic [31:0] if_addr, if_data;
    logic        lsb_enable, lsb_wr, lsb_valid;
    logic [31:0] lsb_addr, lsb_data, lsb_dout;
    logic [2:0]  lsb_len;

    int checks   = 0;
    int failures = 0;
    bit noise    = 1'b0;

    logic [7:0] mem     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(32), .IO_TAG(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
        .io_buffer_full(io_buffer_full),
        .if_enable(if_enable), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .lsb_enable(lsb_enable), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_data(lsb_data),
        .lsb_len(lsb_len), .lsb_valid(lsb_valid), .lsb_dout(lsb_dout)
    );

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ {a[17:16], 6'd0};
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic int norm(input logic [2:0] len);
        return (len == 3'd1 || len == 3'd2) ? int'(len) : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
        return w;
    endfunction

    // Synchronous RAM: data for the address seen at an edge appears after it.
    always @(posedge clk) begin
        ram_din <= ram_rd(ram_a);
        if (ram_wr) mem[ram_a] = ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (noise) begin
            rdy            = ($urandom_range(0, 3) != 0);
            io_buffer_full = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        mem[a]     = b;
        ref_mem[a] = b;
    endtask

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    endtask

    task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] len);
        lsb_enable = 1'b1;
        lsb_wr     = wr;
        lsb_addr   = a;
        lsb_data   = d;
        lsb_len    = len;
    endtask

    task automatic wait_valid(input bit is_lsb, output int n, output logic [31:0] d);
        n = -1;
        d = '0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (is_lsb ? lsb_valid : if_valid) begin
                n = i;
                d = is_lsb ? lsb_dout : if_data;
                break;
            end
        end
        if (n < 0) chk(is_lsb ? "lsb_timeout" : "if_timeout", 32'd0, 32'd1);
    endtask

    // Client drops enable in the DONE cycle; valid must fall on the next edge.
    task automatic finish_txn(input bit is_lsb);
        if (is_lsb) lsb_enable = 1'b0;
        else        if_enable  = 1'b0;
        rdy = 1'b1;
        tick();
        chk(is_lsb ? "lsb_valid_pulse" : "if_valid_pulse",
            32'(is_lsb ? lsb_valid : if_valid), 32'd0);
    endtask

    task automatic run_lsb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] len, input int exp_lat);
        int          n;
        logic [31:0] got;
        lsb_req(wr, a, d, len);
        wait_valid(1'b1, n, got);
        if (exp_lat >= 0) chk("lsb_latency", 32'(n), 32'(exp_lat));
        if (wr) ref_store(a, d, norm(len));
        else    chk("lsb_load_data", got, ref_word(a, norm(len)));
        finish_txn(1'b1);
    endtask

    task automatic run_if(input logic [31:0] a, input int exp_lat);
        int          n;
        logic [31:0] got;
        if_enable = 1'b1;
        if_addr   = a;
        wait_valid(1'b0, n, got);
        if (exp_lat >= 0) chk("if_latency", 32'(n), 32'(exp_lat));
        chk("if_data", got, ref_word(a, 4));
        finish_txn(1'b0);
    endtask

    initial begin
        int          n;
        logic [31:0] got;
        logic [31:0] ra;
        logic [2:0]  rl;
        logic        seen;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_enable = 1'b0; if_addr = '0;
        lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_data = '0; lsb_len = 3'd4;
        preload(32'h100, 8'h78); preload(32'h101, 8'h56);
        preload(32'h102, 8'h34); preload(32'h103, 8'h12);
        repeat (3) tick();

        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_valids", {30'd0, if_valid, lsb_valid}, 32'd0);
        chk("rst_data", if_data | lsb_dout, 32'd0);
        rst = 1'b0;
        tick();

        // LW from 0x100: address walk, then a single valid in cycle 6
        lsb_req(1'b0, 32'h100, 32'h0, 3'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("lw_ram_a", ram_a, 32'h100 + 32'(k));
            chk("lw_ram_wr", 32'(ram_wr), 32'd0);
        end
        tick();
        chk("lw_early_valid", 32'(lsb_valid), 32'd0);
        tick();
        chk("lw_valid", 32'(lsb_valid), 32'd1);
        chk("lw_data", lsb_dout, 32'h12345678);
        finish_txn(1'b1);
        chk("lw_dout_hold", lsb_dout, 32'h12345678);

        // Simultaneous fetch and store byte: LSB wins
        if_enable = 1'b1; if_addr = 32'h0;
        lsb_req(1'b1, 32'h200, 32'h0000_00AB, 3'd1);
        tick();
        chk("arb_ram_wr", 32'(ram_wr), 32'd1);
        chk("arb_ram_a", ram_a, 32'h200);
        chk("arb_ram_dout", 32'(ram_dout), 32'hAB);
        tick();
        chk("arb_lsb_valid", 32'(lsb_valid), 32'd1);
        chk("arb_if_valid", 32'(if_valid), 32'd0);
        ref_store(32'h200, 32'hAB, 1);
        lsb_enable = 1'b0;
        wait_valid(1'b0, n, got);
        chk("arb_if_latency", 32'(n), 32'd6);
        chk("arb_if_data", got, ref_word(32'h0, 4));
        finish_txn(1'b0);
        chk("arb_mem", 32'(ram_rd(32'h200)), 32'hAB);

        // IO store with three cycles of back-pressure
        lsb_req(1'b1, 32'h0003_0000, 32'hDDCC_BBAA, 3'd4);
        io_buffer_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("io_stall_wr", 32'(ram_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        wait_valid(1'b1, n, got);
        chk("io_latency", 32'(n), 32'd4);
        ref_store(32'h0003_0000, 32'hDDCC_BBAA, 4);
        finish_txn(1'b1);
        for (int k = 0; k < 4; k++)
            chk("io_mem", 32'(ram_rd(32'h0003_0000 + 32'(k))), 32'(ref_rd(32'h0003_0000 + 32'(k))));

        // LH aborted by rollback in cycle 2, then a fetch completes normally
        lsb_req(1'b0, 32'h104, 32'h0, 3'd2);
        tick();
        tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        lsb_enable = 1'b0;
        chk("rb_ram_a", ram_a, 32'h105);
        chk("rb_no_valid", 32'(lsb_valid), 32'd0);
        if_enable = 1'b1; if_addr = 32'h100;
        seen = 1'b0;
        n = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            seen = seen | lsb_valid;
            if (if_valid) begin n = i; break; end
        end
        chk("rb_fetch_latency", 32'(n), 32'd5);
        chk("rb_fetch_data", if_data, 32'h12345678);
        chk("rb_lsb_quiet", 32'(seen), 32'd0);
        finish_txn(1'b0);

        // SH with rollback in cycle 1 still completes
        lsb_req(1'b1, 32'h208, 32'h1234_BEEF, 3'd2);
        tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        tick();
        chk("sh_rb_valid", 32'(lsb_valid), 32'd1);
        ref_store(32'h208, 32'h1234_BEEF, 2);
        finish_txn(1'b1);
        chk("sh_rb_mem0", 32'(ram_rd(32'h208)), 32'hEF);
        chk("sh_rb_mem1", 32'(ram_rd(32'h209)), 32'hBE);

        // rdy low for two cycles during a LW delays valid by two cycles
        lsb_req(1'b0, 32'h100, 32'h0, 3'd4);
        tick();
        tick();
        chk("rdy_ram_a0", ram_a, 32'h101);
        rdy = 1'b0;
        tick();
        chk("rdy_ram_a1", ram_a, 32'h101);
        tick();
        chk("rdy_ram_a2", ram_a, 32'h101);
        rdy = 1'b1;
        wait_valid(1'b1, n, got);
        chk("rdy_latency", 32'(n), 32'd3);
        chk("rdy_data", got, 32'h12345678);
        finish_txn(1'b1);

        // rdy low gates ram_wr combinationally; the byte is re-presented
        lsb_req(1'b1, 32'h20C, 32'h0000_0077, 3'd1);
        tick();
        chk("rdyw_wr_on", 32'(ram_wr), 32'd1);
        rdy = 1'b0;
        #1;
        chk("rdyw_wr_gated", 32'(ram_wr), 32'd0);
        tick();
        chk("rdyw_no_valid", 32'(lsb_valid), 32'd0);
        rdy = 1'b1;
        #1;
        chk("rdyw_wr_again", 32'(ram_wr), 32'd1);
        chk("rdyw_ram_a", ram_a, 32'h20C);
        tick();
        chk("rdyw_valid", 32'(lsb_valid), 32'd1);
        ref_store(32'h20C, 32'h77, 1);
        finish_txn(1'b1);

        // Length boundaries and address wrap
        run_lsb(1'b0, 32'h103, 32'h0, 3'd1, 2);
        run_lsb(1'b0, 32'h100, 32'h0, 3'd3, 5);
        run_lsb(1'b0, 32'hFFFF_FFFE, 32'h0, 3'd4, 5);

        // Reset mid-transfer produces no valid pulse
        lsb_req(1'b0, 32'h100, 32'h0, 3'd4);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_ram_a", ram_a, 32'd0);
        rst = 1'b0;
        lsb_enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | lsb_valid;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);

        // Randomized traffic with rdy and IO back-pressure noise
        for (int t = 0; t < 40; t++) begin
            noise = 1'b1;
            ra = ($urandom_range(0, 3) == 0) ? (32'h0003_0000 + 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 1023));
            case ($urandom_range(0, 4))
                0:       rl = 3'd1;
                1:       rl = 3'd2;
                2:       rl = 3'd4;
                3:       rl = 3'd3;
                default: rl = 3'd0;
            endcase
            case ($urandom_range(0, 3))
                0:       run_if(ra, -1);
                1, 2:    run_lsb(1'b1, ra, $urandom, rl, -1);
                default: run_lsb(1'b0, ra, 32'h0, rl, -1);
            endcase
        end
        noise = 1'b0;
        rdy = 1'b1;
        io_buffer_full = 1'b0;
        tick();

        foreach (ref_mem[a]) chk("final_mem", 32'(ram_rd(a)), 32'(ref_mem[a]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_ctrl
`default_nettype wire
